// File: rtl/rf_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_sb_bits.sv
// Per-register pending-write bits: set on reserve, clear on write, set wins.
module rf_sb_bits #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] tap_addr_a_i,
  input  logic [ADDR_W-1:0] tap_addr_b_i,
  output logic              tap_a_o,
  output logic              tap_b_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign tap_a_o = pend_q[tap_addr_a_i];
  assign tap_b_o = pend_q[tap_addr_b_i];

endmodule

// File: rtl/rf_scoreboard_regfile.sv
// 2R1W register file with clear sequencer and pending-write scoreboard.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module rf_scoreboard_regfile
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] reg_address_1,
  input  logic [ADDR_W-1:0] reg_address_2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd1_pend,
  output logic              rd2_pend,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_address,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  rf_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [NREGS];

  logic run_c;
  logic wr_en_c;
  logic rsv_en_c;
  logic tap1_c;
  logic tap2_c;

  assign run_c    = (state_q == RUN);
  assign wr_en_c  = run_c && we  && (write_address != ZERO_ADDR);
  assign rsv_en_c = run_c && rsv && (rsv_address   != ZERO_ADDR);
  assign ready    = ready_q;

  // Clear sequencer; the extra counter bit means the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NREGS - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ready_q <= 1'b1;
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR)  mem_q[cnt_q[ADDR_W-1:0]] <= '0;
      else if (wr_en_c)      mem_q[write_address]      <= data;
    end
  end

  rf_sb_bits #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .set_i        (rsv_en_c),
    .set_addr_i   (rsv_address),
    .clr_i        (wr_en_c),
    .clr_addr_i   (write_address),
    .tap_addr_a_i (reg_address_1),
    .tap_addr_b_i (reg_address_2),
    .tap_a_o      (tap1_c),
    .tap_b_o      (tap2_c)
  );

  // Read port 1: zero while clearing or for register 0.
  always_comb begin
    rd1      = '0;
    rd1_pend = 1'b0;
    if (run_c && (reg_address_1 != ZERO_ADDR)) begin
      rd1      = mem_q[reg_address_1];
      rd1_pend = tap1_c;
`ifdef RF_BYPASS_EN
      if (wr_en_c && (write_address == reg_address_1)) begin
        rd1      = data;
        rd1_pend = rsv_en_c && (rsv_address == reg_address_1);
      end
`endif
    end
  end

  always_comb begin
    rd2      = '0;
    rd2_pend = 1'b0;
    if (run_c && (reg_address_2 != ZERO_ADDR)) begin
      rd2      = mem_q[reg_address_2];
      rd2_pend = tap2_c;
`ifdef RF_BYPASS_EN
      if (wr_en_c && (write_address == reg_address_2)) begin
        rd2      = data;
        rd2_pend = rsv_en_c && (rsv_address == reg_address_2);
      end
`endif
    end
  end

endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
// Self-checking bench for rf_scoreboard_regfile against an array-based reference model.
module tb_rf_scoreboard_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [4:0]  reg_address_1, reg_address_2;
  logic [31:0] rd1, rd2;
  logic        rd1_pend, rd2_pend;
  logic        rsv;
  logic [4:0]  rsv_address;
  logic        we;
  logic [4:0]  write_address;
  logic [31:0] data;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_ready;
  int          m_clr;

  logic [31:0] o_rd1, o_rd2;
  logic        o_p1, o_p2, o_ready;

  rf_scoreboard_regfile dut (
    .clk           (clk),
    .reset         (reset),
    .ready         (ready),
    .reg_address_1 (reg_address_1),
    .reg_address_2 (reg_address_2),
    .rd1           (rd1),
    .rd2           (rd2),
    .rd1_pend      (rd1_pend),
    .rd2_pend      (rd2_pend),
    .rsv           (rsv),
    .rsv_address   (rsv_address),
    .we            (we),
    .write_address (write_address),
    .data          (data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read for one port, from the model state before the coming edge.
  task automatic expect_rd(input logic [4:0] a, input logic w, input logic [4:0] wa,
                           input logic [31:0] d, input logic s, input logic [4:0] sa,
                           output logic [31:0] ed, output logic ep);
    ed = 32'h0;
    ep = 1'b0;
    if (m_ready && a != 5'd0) begin
      ed = m_mem[a];
      ep = m_pend[a];
`ifdef RF_BYPASS_EN
      if (w && wa == a) begin
        ed = d;
        ep = s && (sa == a);
      end
`endif
    end
  endtask

  // Starts and ends at a falling edge; checks outputs, then advances the model one edge.
  task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] d,
                      input logic s, input logic [4:0] sa, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] e1, e2;
    logic        p1, p2;
    reset = r; we = w; write_address = wa; data = d;
    rsv = s; rsv_address = sa; reg_address_1 = a1; reg_address_2 = a2;
    #1;
    expect_rd(a1, w, wa, d, s, sa, e1, p1);
    expect_rd(a2, w, wa, d, s, sa, e2, p2);
    o_rd1 = rd1; o_rd2 = rd2; o_p1 = rd1_pend; o_p2 = rd2_pend; o_ready = ready;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rd1", rd1, e1);
    chk("rd2", rd2, e2);
    chk("rd1_pend", 32'(rd1_pend), 32'(p1));
    chk("rd2_pend", 32'(rd2_pend), 32'(p2));
    @(posedge clk);
    if (r) begin
      m_ready = 1'b0;
      m_clr   = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else if (!m_ready) begin
      m_clr++;
      if (m_clr == 32) begin
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      end
    end else begin
      if (w && wa != 5'd0) begin
        m_mem[wa]  = d;
        m_pend[wa] = 1'b0;
      end
      if (s && sa != 5'd0) m_pend[sa] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a1, a2);
  endtask

  // Steps idle until ready is seen; lat is the step number where it first reads 1.
  task automatic measure(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) step(1'b0, 1'b1, 5'd9, 32'hABCD0009, 1'b1, 5'd9, 5'd9, 5'd0);
      else        idle(5'd9, 5'd0);
      if (o_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [31:0] old3;
    reset = 1'b1; we = 1'b0; rsv = 1'b0; data = '0;
    write_address = '0; rsv_address = '0; reg_address_1 = '0; reg_address_2 = '0;
    m_ready = 1'b0; m_clr = 0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = $urandom;
      m_pend[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);

    // Reset state and clear latency
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    chk("reset_ready", 32'(o_ready), 32'h0);
    measure(lat);
    chk("clear_latency", 32'(lat), 32'd33);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
    chk("clr_we_dropped", o_rd1, 32'h0);

    // Basic write and address 0
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd5, 5'd0);
    chk("wr5", o_rd1, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("r0_data", o_rd1, 32'h0);
    chk("r0_pend", 32'(o_p2), 32'h0);

    // Reservation, retire, and same-cycle reserve+write
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7);
    idle(5'd0, 5'd7);
    chk("rsv7_pend", 32'(o_p2), 32'h1);
    step(1'b0, 1'b1, 5'd7, 32'h42, 1'b0, 5'd0, 5'd0, 5'd7);
    idle(5'd0, 5'd7);
    chk("wr7_data", o_rd2, 32'h42);
    chk("wr7_pend", 32'(o_p2), 32'h0);
    step(1'b0, 1'b1, 5'd7, 32'h43, 1'b1, 5'd7, 5'd0, 5'd7);
    idle(5'd0, 5'd7);
    chk("rsvwr7_pend", 32'(o_p2), 32'h1);
    chk("rsvwr7_data", o_rd2, 32'h43);

    // Same-cycle read of the register being written
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0);
    old3 = 32'h11;
    step(1'b0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd3, 5'd0);
`ifdef RF_BYPASS_EN
    chk("bypass3", o_rd1, 32'h55);
`else
    chk("nobypass3", o_rd1, old3);
`endif

    // Reset mid-RUN and mid-CLEAR restarts the sequence
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
    for (int k = 0; k < 10; k++) idle(5'd5, 5'd7);
    chk("midclr_rd", o_rd1, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
    measure(lat);
    chk("midclr_latency", 32'(lat), 32'd33);
    idle(5'd5, 5'd7);
    chk("after_clr_r5", o_rd1, 32'h0);
    chk("after_clr_p7", 32'(o_p2), 32'h0);

    // Randomised traffic
    for (int n = 0; n < 10000; n++) begin
      logic r;
      r = ($urandom_range(0, 2999) == 0);
      step(r, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           ($urandom_range(0, 9) < 3), 5'($urandom), 5'($urandom), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
